// File: rtl/vec_addr_setup.sv
// Upstream setup stage for the vector register address generator.
// Takes one request, converts vl/SEW/LMUL into a register/offset range,
// launches the generator and reports completion. One operation in flight.
module vec_addr_setup #(
    parameter int unsigned VLEN       = 16384,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned OFF_WIDTH  = $clog2(VLEN / DATA_WIDTH),
    parameter int unsigned VL_WIDTH   = $clog2(VLEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_vreg,
    input  logic [VL_WIDTH-1:0]   req_vl,
    input  logic [1:0]            req_sew,
    input  logic [1:0]            req_lmul,
    input  logic                  req_widen,
    output logic                  agu_en,
    input  logic                  agu_ack,
    input  logic                  agu_idle,
    output logic [ADDR_WIDTH-1:0] agu_addr_in,
    output logic [OFF_WIDTH-1:0]  agu_off_in,
    output logic [ADDR_WIDTH-1:0] agu_max_reg_in,
    output logic [OFF_WIDTH-1:0]  agu_max_off_in,
    output logic                  agu_widen_in,
    input  logic                  agu_addr_valid,
    input  logic                  agu_addr_end,
    output logic                  done,
    output logic                  err
);

    // Wide enough to hold VLEN*8 (largest VLEN << lmul) without overflow.
    localparam int unsigned CW      = $clog2(VLEN) + 4;
    localparam int unsigned BPW     = DATA_WIDTH / 8;
    localparam int unsigned BPW_LOG = $clog2(BPW);

    typedef enum logic [1:0] {StIdle, StCalc, StIssue, StBusy} state_e;

    state_e state_q, state_d;

    // Captured request fields
    logic [ADDR_WIDTH-1:0] vreg_q;
    logic [VL_WIDTH-1:0]   vl_q;
    logic [1:0]            sew_q;
    logic [1:0]            lmul_q;
    logic                  widen_q;

    // Generator-facing registers, updated on leaving StCalc
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] max_reg_q;
    logic [OFF_WIDTH-1:0]  max_off_q;
    logic                  agu_widen_q;
    logic                  err_q;

    // Range arithmetic
    logic [CW-1:0]         vlmax, vl_ext, vl_eff, bytes, words, last;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic                  err_calc;
    logic                  launch;

    // Convert the captured vl/SEW/LMUL into word count and end position
    always_comb begin
        vlmax      = (CW'(VLEN) << lmul_q) >> (32'd3 + 32'(sew_q));
        vl_ext     = CW'(vl_q);
        vl_eff     = (vl_ext > vlmax) ? vlmax : vl_ext;
        bytes      = vl_eff << sew_q;
        words      = (bytes + CW'(BPW - 1)) >> BPW_LOG;
        last       = words - CW'(1);
        align_mask = ADDR_WIDTH'((32'd1 << lmul_q) - 32'd1);
        err_calc   = (vl_ext > vlmax) || ((lmul_q != 2'd0) && ((vreg_q & align_mask) != '0));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid) state_d = StCalc;
            StCalc:  state_d = (words == '0) ? StIdle : StIssue;
            StIssue: begin
                if (agu_ack && agu_idle) begin
                    state_d = (agu_addr_end && agu_addr_valid) ? StIdle : StBusy;
                end
            end
            StBusy:  if (agu_addr_valid && agu_addr_end && agu_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; done is raised in the same cycle as the terminating event
    always_comb begin
        req_ready = (state_q == StIdle);
        agu_en    = (state_q == StIssue);
        launch    = (state_q == StIssue) && agu_ack && agu_idle;
        done      = ((state_q == StCalc) && (words == '0))
                 || (launch && agu_addr_end && agu_addr_valid)
                 || ((state_q == StBusy) && agu_addr_valid && agu_addr_end && agu_ack);
        // In StCalc the error flag is not registered yet, so use it directly
        err       = done && ((state_q == StCalc) ? err_calc : err_q);
    end

    // Capture request fields on handshake and generator fields on leaving StCalc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vreg_q      <= '0;
            vl_q        <= '0;
            sew_q       <= '0;
            lmul_q      <= '0;
            widen_q     <= 1'b0;
            addr_q      <= '0;
            max_reg_q   <= '0;
            max_off_q   <= '0;
            agu_widen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (state_q == StIdle && req_valid) begin
                vreg_q  <= req_vreg;
                vl_q    <= req_vl;
                sew_q   <= req_sew;
                lmul_q  <= req_lmul;
                widen_q <= req_widen;
            end
            if (state_q == StCalc) begin
                addr_q      <= vreg_q;
                max_reg_q   <= ADDR_WIDTH'(last >> OFF_WIDTH);
                max_off_q   <= last[OFF_WIDTH-1:0];
                agu_widen_q <= widen_q;
                err_q       <= err_calc;
            end
        end
    end

    assign agu_addr_in    = addr_q;
    assign agu_off_in     = '0;
    assign agu_max_reg_in = max_reg_q;
    assign agu_max_off_in = max_off_q;
    assign agu_widen_in   = agu_widen_q;

endmodule
